// File: rtl/timing_sequencer.sv
// ---------------------------------------------------------------------------
// timing_sequencer
//
// Instruction phase sequencer for a simple control unit. It steps through the
// fetch (T0), decode (T1), execute (T2) and optional indirect-operand (T3)
// phases, owns the instruction register and the program counter, and parks in
// a HALT state when the halt opcode is decoded.
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   mem_data   : memory read data, captured as the instruction word in T0
//   mem_ready  : memory handshake, current memory phase completes this cycle
//   pcadd_en   : PC increment request, honoured only on the T0 exit edge
//   selpc      : PC load (jump) request, honoured only on the last-phase exit
//   resume     : leaves HALT on the next edge
//   T0..T3     : registered one-hot phase strobes (all low in HALT)
//   instr      : instruction register
//   modebits   : instr[31:30]
//   opcode     : instr[29:24]
//   pc         : program counter, the memory address during T0
//   halted     : registered, high while in HALT
//   mode_err   : sticky flag for the illegal addressing mode 2'b11
// ---------------------------------------------------------------------------
module timing_sequencer #(
  parameter int         PC_W    = 8,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     mem_data,
  input  logic            mem_ready,
  input  logic            pcadd_en,
  input  logic            selpc,
  input  logic            resume,
  output logic            T0,
  output logic            T1,
  output logic            T2,
  output logic            T3,
  output logic [31:0]     instr,
  output logic [1:0]      modebits,
  output logic [5:0]      opcode,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            mode_err
);

  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [1:0] MODE_INDIRECT = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL  = 2'b11;

  state_t state;
  state_t state_next;

  // Edge qualifiers: the fetch completes when T0 sees mem_ready, and the
  // instruction completes at the exit of its final phase (T2 for direct
  // modes, T3 for the indirect mode).
  logic fetch_done;
  logic last_done;
  logic is_indirect;

  assign modebits    = instr[31:30];
  assign opcode      = instr[29:24];
  assign is_indirect = (modebits == MODE_INDIRECT);

  assign fetch_done = (state == S_T0) && mem_ready;
  assign last_done  = ((state == S_T2) && mem_ready && !is_indirect) ||
                      ((state == S_T3) && mem_ready);

  // Next-state selection; mode 2'b11 falls through the direct path, which
  // makes it sequence exactly like mode 2'b00.
  always_comb begin
    state_next = state;
    case (state)
      S_T0: begin
        if (mem_ready) state_next = S_T1;
      end
      S_T1: begin
        if (opcode == HALT_OP) state_next = S_HALT;
        else                   state_next = S_T2;
      end
      S_T2: begin
        if (mem_ready) state_next = is_indirect ? S_T3 : S_T0;
      end
      S_T3: begin
        if (mem_ready) state_next = S_T0;
      end
      S_HALT: begin
        if (resume) state_next = S_T0;
      end
      default: state_next = S_T0;
    endcase
  end

  // Strobes and halted are registered copies of the next-state decode, so
  // they change together with the state register and carry no input paths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_T0;
      T0       <= 1'b1;
      T1       <= 1'b0;
      T2       <= 1'b0;
      T3       <= 1'b0;
      halted   <= 1'b0;
      instr    <= 32'd0;
      pc       <= '0;
      mode_err <= 1'b0;
    end else begin
      state  <= state_next;
      T0     <= (state_next == S_T0);
      T1     <= (state_next == S_T1);
      T2     <= (state_next == S_T2);
      T3     <= (state_next == S_T3);
      halted <= (state_next == S_HALT);

      if (fetch_done) begin
        instr <= mem_data;
      end

      // fetch_done and last_done are mutually exclusive by state, but the
      // load is still given priority so a jump can never be lost.
      if (last_done && selpc) begin
        pc <= instr[PC_W-1:0];
      end else if (fetch_done && pcadd_en) begin
        pc <= pc + PC_W'(1);
      end

      if ((state == S_T1) && (modebits == MODE_ILLEGAL)) begin
        mode_err <= 1'b1;
      end
    end
  end

endmodule
